prt_dprx_lnk_sym_parse: RTL and testbench
=========================================

Name: prt_dprx_lnk_sym_parse

Overview:
- Receive-side single-lane link symbol parser: the counterpart of the TX link framer.
- Takes decoded link symbols from the RX PHY, P_SPL per clock, and tracks SST framing (BS/SR, VB-ID, Mvid, Maud, BE, fill, secondary data).
- Outputs active-video data bytes with per-symbol valid flags, VB-ID/timing pulses, measured active line length and framing errors.
- Sits between the RX PHY lane and the RX video unpacker; the lane deskew stage instantiates one per lane.

Parameters:
P_SPL, 2, symbols per lane per clock (2 or 4)
P_LEN_W, 16, width of active-line symbol counter

Ports:
LNK_CLK_IN  in  1  link clock
LNK_RST_IN  in  1  asynchronous reset, active-low
LNK_EN_IN  in  1  PHY lock/enable; low forces IDLE
LNK_DAT_IN  in  P_SPL*11  symbols; slot j = bits [j*11+:11] = {disp_ctl, disp_val, k, dat[7:0]}; slot 0 earliest; bits 10:9 ignored
DAT_OUT  out  P_SPL*8  data bytes, slot-aligned with input
DAT_VLD_OUT  out  P_SPL  per-slot active-video valid
LOCK_OUT  out  1  framing locked
VBID_OUT  out  8  last captured VB-ID
VBID_UPD_OUT  out  1  pulse: VB-ID captured
MVID_OUT  out  8  last captured Mvid[7:0]
VS_OUT  out  1  vertical blank (= VBID_OUT[0])
SOF_OUT  out  1  pulse: VB-ID bit0 1->0 (start of frame)
BS_OUT  out  1  pulse: BS or SR seen
BE_OUT  out  1  pulse: BE seen
LINE_LEN_OUT  out  P_LEN_W  active data symbol count of last line
LINE_LEN_UPD_OUT  out  1  pulse: LINE_LEN_OUT updated
ERR_OUT  out  1  pulse: framing error

Behaviour:
- Reset: every output 0; state IDLE; counter 0.
- K codes (k=1):
  - BS = 0xBC; SR = 0x1C, treated identically to BS.
  - BE = 0xFB, SS = 0x5C, SE = 0xFD, FS = 0xFE, FE = 0xF7.
  - Any other K is "unknown".
- States: IDLE, VBID, MVID, MAUD, BLANK, SDP, ACTIVE, FILL.
- Slot processing:
  - All P_SPL slots are processed sequentially within one clock as a combinational chain, slot 0 first.
  - The state after slot j is the state for slot j+1; the registered state after the last slot carries to the next cycle.
- Transitions:
  - Any state, BS/SR -> VBID. If the prior state was ACTIVE or FILL, latch the counter into LINE_LEN_OUT, pulse LINE_LEN_UPD_OUT, and clear the counter.
  - VBID, data symbol: capture VBID_OUT and pulse VBID_UPD_OUT -> MVID.
  - MVID, data symbol: capture MVID_OUT -> MAUD.
  - MAUD, data symbol -> BLANK. LOCK_OUT goes 1 on this transition.
  - BLANK, BE -> ACTIVE; BLANK, SS -> SDP; SDP, SE -> BLANK.
  - ACTIVE, data symbol: slot valid, counter +1, saturating at all-ones.
  - ACTIVE, FS -> FILL; FILL, FE -> ACTIVE.
  - FILL and BLANK data symbols are never valid.
- Valid and data:
  - DAT_VLD_OUT[j] = 1 only for a data symbol processed in ACTIVE.
  - Control symbols, and data in any other state, give valid 0.
  - DAT_OUT passes dat for all slots regardless of valid.
- Latency: all outputs registered, 1 clock after the input word.
- Fatal errors: pulse ERR_OUT, go to IDLE, LOCK_OUT = 0, clear counter.
  - K symbol in VBID, MVID or MAUD.
  - BE outside BLANK.
  - FE outside FILL.
  - SE outside SDP.
  - FS outside ACTIVE.
  - SS outside BLANK.
- Non-fatal errors:
  - Unknown K in any state: ERR_OUT pulse, state unchanged, slot not valid.
  - IDLE ignores everything except BS/SR, with no error.
- SOF_OUT: pulses when a new VB-ID has bit0 = 0 and the previous VBID_OUT bit0 = 1.
- Multiple events in one word:
  - Pulses are single-cycle ORs.
  - Captured values take the last occurrence in the word.
  - LINE_LEN_OUT takes the count at the latching BS.
  - An error followed by a BS in a later slot of the same word relocks normally from that BS.
- LNK_EN_IN low: next cycle state IDLE, LOCK_OUT = 0, DAT_VLD_OUT = 0, counter cleared. No ERR pulse. Captured VBID/MVID/LINE_LEN are held.
- Async reset mid-line: immediate return to reset values.

Test Plan:
1. Reset held low for 5 clocks, then released with all-zero symbols -> all outputs 0, LOCK_OUT 0. Then send BS, 0x01, 0x12, 0x00 -> VBID_OUT 0x01, MVID_OUT 0x12, VS_OUT 1, VBID_UPD_OUT one-cycle pulse, LOCK_OUT 1, output 1 clock after the last input.
2. P_SPL=2, locked, BE in slot 1, then data 0..99, then BS -> DAT_VLD_OUT pattern 2'b00, then 2'b11 x50; bytes in order 0..99; LINE_LEN_OUT=100 with LINE_LEN_UPD_OUT pulse on the BS cycle.
3. Active line: 10 data, FS, 3x 0x00, FE, 10 data, BS -> pad symbols invalid, LINE_LEN_OUT=20, no ERR.
4. VB-ID 0x01 on one BS, then 0x00 on the next BS -> SOF_OUT single pulse on the second, VS_OUT 1->0. Repeat using SR instead of BS -> identical result.
5. FE in BLANK -> ERR_OUT pulse, LOCK_OUT 0, no valids until BS/VBID/Mvid/Maud recover lock. Unknown K 0x3C in ACTIVE -> ERR_OUT pulse, LOCK_OUT stays 1, count unaffected.
6. LNK_EN_IN low for 1 clock mid-line (count 37), then a new line of 8 symbols -> no ERR; IDLE until BS; LINE_LEN_OUT reflects 8 at the next latch. P_SPL=4 rerun of scenario 2 with BE in slot 2 -> valid 4'b1000 in the first word.

Source files
------------

// File: rtl/prt_dprx_lnk_sym_parse.sv
// RX single-lane SST link symbol parser: tracks BS/VB-ID/Mvid/Maud/BE/fill/SDP framing, emits active bytes.
// Latency 1 clk, all outputs registered; no backpressure (the PHY symbol stream never stalls).
module prt_dprx_lnk_sym_parse #(
    parameter int P_SPL   = 2,
    parameter int P_LEN_W = 16
) (
    input  logic                 LNK_CLK_IN,
    input  logic                 LNK_RST_IN,
    input  logic                 LNK_EN_IN,
    input  logic [P_SPL*11-1:0]  LNK_DAT_IN,
    output logic [P_SPL*8-1:0]   DAT_OUT,
    output logic [P_SPL-1:0]     DAT_VLD_OUT,
    output logic                 LOCK_OUT,
    output logic [7:0]           VBID_OUT,
    output logic                 VBID_UPD_OUT,
    output logic [7:0]           MVID_OUT,
    output logic                 VS_OUT,
    output logic                 SOF_OUT,
    output logic                 BS_OUT,
    output logic                 BE_OUT,
    output logic [P_LEN_W-1:0]   LINE_LEN_OUT,
    output logic                 LINE_LEN_UPD_OUT,
    output logic                 ERR_OUT
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VBID   = 3'd1;
    localparam logic [2:0] S_MVID   = 3'd2;
    localparam logic [2:0] S_MAUD   = 3'd3;
    localparam logic [2:0] S_BLANK  = 3'd4;
    localparam logic [2:0] S_SDP    = 3'd5;
    localparam logic [2:0] S_ACTIVE = 3'd6;
    localparam logic [2:0] S_FILL   = 3'd7;

    localparam logic [7:0] K_BS = 8'hBC;
    localparam logic [7:0] K_SR = 8'h1C;
    localparam logic [7:0] K_BE = 8'hFB;
    localparam logic [7:0] K_SS = 8'h5C;
    localparam logic [7:0] K_SE = 8'hFD;
    localparam logic [7:0] K_FS = 8'hFE;
    localparam logic [7:0] K_FE = 8'hF7;

    localparam logic [P_LEN_W-1:0] LEN_ONE = {{(P_LEN_W-1){1'b0}}, 1'b1};

    logic [2:0]         st_q, st_n;
    logic [P_LEN_W-1:0] cnt_q, cnt_n;
    logic               lock_n, vbid_upd_n, sof_n, bs_n, be_n, len_upd_n, err_n;
    logic [7:0]         vbid_n, mvid_n;
    logic [P_LEN_W-1:0] len_n;
    logic [P_SPL*8-1:0] dat_n;
    logic [P_SPL-1:0]   vld_n;
    logic               sym_k, fatal;
    logic [7:0]         sym_d;
    logic               unused_disp;

    // Disparity bits are consumed by the PHY decoder only.
    assign unused_disp = ^LNK_DAT_IN;
    assign VS_OUT      = VBID_OUT[0];

    always_comb begin
        st_n       = st_q;
        cnt_n      = cnt_q;
        lock_n     = LOCK_OUT;
        vbid_n     = VBID_OUT;
        mvid_n     = MVID_OUT;
        len_n      = LINE_LEN_OUT;
        dat_n      = '0;
        vld_n      = '0;
        vbid_upd_n = 1'b0;
        sof_n      = 1'b0;
        bs_n       = 1'b0;
        be_n       = 1'b0;
        len_upd_n  = 1'b0;
        err_n      = 1'b0;
        sym_k      = 1'b0;
        sym_d      = '0;
        fatal      = 1'b0;
        for (int j = 0; j < P_SPL; j++) begin
            sym_k            = LNK_DAT_IN[j*11+8];
            sym_d            = LNK_DAT_IN[j*11+:8];
            dat_n[j*8+:8]    = sym_d;
            fatal            = 1'b0;
            if (sym_k && (sym_d == K_BS || sym_d == K_SR)) begin
                bs_n = 1'b1;
                if (st_n == S_ACTIVE || st_n == S_FILL) begin
                    len_n     = cnt_n;
                    len_upd_n = 1'b1;
                    cnt_n     = '0;
                end
                st_n = S_VBID;
            end else if (st_n == S_IDLE) begin
                // Unlocked: wait silently for the next BS/SR.
            end else if (sym_k) begin
                case (sym_d)
                    K_BE: begin
                        be_n = 1'b1;
                        if (st_n == S_BLANK) st_n = S_ACTIVE;
                        else                 fatal = 1'b1;
                    end
                    K_SS:    if (st_n == S_BLANK)  st_n = S_SDP;    else fatal = 1'b1;
                    K_SE:    if (st_n == S_SDP)    st_n = S_BLANK;  else fatal = 1'b1;
                    K_FS:    if (st_n == S_ACTIVE) st_n = S_FILL;   else fatal = 1'b1;
                    K_FE:    if (st_n == S_FILL)   st_n = S_ACTIVE; else fatal = 1'b1;
                    default: err_n = 1'b1;
                endcase
            end else begin
                case (st_n)
                    S_VBID: begin
                        sof_n      = sof_n | (vbid_n[0] & ~sym_d[0]);
                        vbid_n     = sym_d;
                        vbid_upd_n = 1'b1;
                        st_n       = S_MVID;
                    end
                    S_MVID: begin
                        mvid_n = sym_d;
                        st_n   = S_MAUD;
                    end
                    S_MAUD: begin
                        lock_n = 1'b1;
                        st_n   = S_BLANK;
                    end
                    S_ACTIVE: begin
                        vld_n[j] = 1'b1;
                        if (cnt_n != '1) cnt_n = cnt_n + LEN_ONE;
                    end
                    default: ;
                endcase
            end
            if (fatal) begin
                err_n  = 1'b1;
                st_n   = S_IDLE;
                lock_n = 1'b0;
                cnt_n  = '0;
            end
        end
        // Lane disable drops lock quietly but keeps the last captured values.
        if (!LNK_EN_IN) begin
            st_n       = S_IDLE;
            cnt_n      = '0;
            lock_n     = 1'b0;
            vbid_n     = VBID_OUT;
            mvid_n     = MVID_OUT;
            len_n      = LINE_LEN_OUT;
            vld_n      = '0;
            vbid_upd_n = 1'b0;
            sof_n      = 1'b0;
            bs_n       = 1'b0;
            be_n       = 1'b0;
            len_upd_n  = 1'b0;
            err_n      = 1'b0;
        end
    end

    always_ff @(posedge LNK_CLK_IN or negedge LNK_RST_IN) begin
        if (!LNK_RST_IN) begin
            st_q             <= S_IDLE;
            cnt_q            <= '0;
            DAT_OUT          <= '0;
            DAT_VLD_OUT      <= '0;
            LOCK_OUT         <= 1'b0;
            VBID_OUT         <= '0;
            VBID_UPD_OUT     <= 1'b0;
            MVID_OUT         <= '0;
            SOF_OUT          <= 1'b0;
            BS_OUT           <= 1'b0;
            BE_OUT           <= 1'b0;
            LINE_LEN_OUT     <= '0;
            LINE_LEN_UPD_OUT <= 1'b0;
            ERR_OUT          <= 1'b0;
        end else begin
            st_q             <= st_n;
            cnt_q            <= cnt_n;
            DAT_OUT          <= dat_n;
            DAT_VLD_OUT      <= vld_n;
            LOCK_OUT         <= lock_n;
            VBID_OUT         <= vbid_n;
            VBID_UPD_OUT     <= vbid_upd_n;
            MVID_OUT         <= mvid_n;
            SOF_OUT          <= sof_n;
            BS_OUT           <= bs_n;
            BE_OUT           <= be_n;
            LINE_LEN_OUT     <= len_n;
            LINE_LEN_UPD_OUT <= len_upd_n;
            ERR_OUT          <= err_n;
        end
    end
endmodule

// File: tb/tb_prt_dprx_lnk_sym_parse.sv
// Bench: one symbol stream feeds a 2-slot and a 4-slot parser; a symbol-level reference model fills per-instance scoreboards.
module tb_prt_dprx_lnk_sym_parse;
    localparam int M_IDLE = 0, M_VBID = 1, M_MVID = 2, M_MAUD = 3, M_BLANK = 4, M_SDP = 5, M_ACTIVE = 6, M_FILL = 7;
    localparam int C_DAT = 0, C_BS = 1, C_BE = 2, C_SS = 3, C_SE = 4, C_FS = 5, C_FE = 6, C_UNK = 7;

    typedef struct {
        logic [31:0] dat;
        logic [3:0]  vld;
        logic        lock;
        logic [7:0]  vbid;
        logic        upd;
        logic [7:0]  mvid;
        logic        vs;
        logic        sof;
        logic        bs;
        logic        be;
        logic [15:0] len;
        logic        lupd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en2, en4;
    logic [21:0] din2;
    logic [43:0] din4;
    logic [15:0] dat2;
    logic [31:0] dat4;
    logic [1:0]  vld2;
    logic [3:0]  vld4;
    logic        lock_o [2];
    logic [7:0]  vbid_o [2];
    logic        upd_o  [2];
    logic [7:0]  mvid_o [2];
    logic        vs_o   [2];
    logic        sof_o  [2];
    logic        bs_o   [2];
    logic        be_o   [2];
    logic [15:0] len_o  [2];
    logic        lupd_o [2];
    logic        err_o  [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit drv_on = 1'b0;

    logic [11:0] sq [2][$];
    exp_t        eq [2][$];

    int          m_st   [2];
    int          m_cnt  [2];
    logic        m_lock [2];
    logic [7:0]  m_vbid [2];
    logic [7:0]  m_mvid [2];
    logic [15:0] m_len  [2];

    always #5 clk = ~clk;

    prt_dprx_lnk_sym_parse #(.P_SPL(2), .P_LEN_W(16)) u_dut2 (
        .LNK_CLK_IN(clk), .LNK_RST_IN(rst_n), .LNK_EN_IN(en2), .LNK_DAT_IN(din2),
        .DAT_OUT(dat2), .DAT_VLD_OUT(vld2), .LOCK_OUT(lock_o[0]), .VBID_OUT(vbid_o[0]),
        .VBID_UPD_OUT(upd_o[0]), .MVID_OUT(mvid_o[0]), .VS_OUT(vs_o[0]), .SOF_OUT(sof_o[0]),
        .BS_OUT(bs_o[0]), .BE_OUT(be_o[0]), .LINE_LEN_OUT(len_o[0]),
        .LINE_LEN_UPD_OUT(lupd_o[0]), .ERR_OUT(err_o[0])
    );

    prt_dprx_lnk_sym_parse #(.P_SPL(4), .P_LEN_W(16)) u_dut4 (
        .LNK_CLK_IN(clk), .LNK_RST_IN(rst_n), .LNK_EN_IN(en4), .LNK_DAT_IN(din4),
        .DAT_OUT(dat4), .DAT_VLD_OUT(vld4), .LOCK_OUT(lock_o[1]), .VBID_OUT(vbid_o[1]),
        .VBID_UPD_OUT(upd_o[1]), .MVID_OUT(mvid_o[1]), .VS_OUT(vs_o[1]), .SOF_OUT(sof_o[1]),
        .BS_OUT(bs_o[1]), .BE_OUT(be_o[1]), .LINE_LEN_OUT(len_o[1]),
        .LINE_LEN_UPD_OUT(lupd_o[1]), .ERR_OUT(err_o[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [10:0] s);
        if (!s[8]) return C_DAT;
        case (s[7:0])
            8'hBC, 8'h1C: return C_BS;
            8'hFB:        return C_BE;
            8'h5C:        return C_SS;
            8'hFD:        return C_SE;
            8'hFE:        return C_FS;
            8'hF7:        return C_FE;
            default:      return C_UNK;
        endcase
    endfunction

    // Legal framing control transitions; anything else is a fatal framing error.
    function automatic int legal_next(input int s, input int c);
        if (s == M_BLANK  && c == C_BE) return M_ACTIVE;
        if (s == M_BLANK  && c == C_SS) return M_SDP;
        if (s == M_SDP    && c == C_SE) return M_BLANK;
        if (s == M_ACTIVE && c == C_FS) return M_FILL;
        if (s == M_FILL   && c == C_FE) return M_ACTIVE;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = M_IDLE; m_cnt[i] = 0; m_lock[i] = 1'b0;
            m_vbid[i] = '0; m_mvid[i] = '0; m_len[i] = '0;
        end
    endtask

    task automatic apply_word(input int i, input logic [43:0] w, input logic en, input int n);
        exp_t e;
        int   c;
        logic [7:0] d;
        e = '{default: 0};
        for (int j = 0; j < n; j++) e.dat[j*8+:8] = w[j*11+:8];
        if (!en) begin
            m_st[i] = M_IDLE; m_lock[i] = 1'b0; m_cnt[i] = 0;
        end else begin
            for (int j = 0; j < n; j++) begin
                c = cls_of(w[j*11+:11]);
                d = w[j*11+:8];
                if (c == C_BS) begin
                    e.bs = 1'b1;
                    if (m_st[i] == M_ACTIVE || m_st[i] == M_FILL) begin
                        m_len[i] = 16'(m_cnt[i]); e.lupd = 1'b1; m_cnt[i] = 0;
                    end
                    m_st[i] = M_VBID;
                end else if (m_st[i] == M_IDLE) begin
                end else if (c == C_UNK) begin
                    e.err = 1'b1;
                end else if (c != C_DAT) begin
                    if (c == C_BE) e.be = 1'b1;
                    if (legal_next(m_st[i], c) < 0) begin
                        e.err = 1'b1; m_st[i] = M_IDLE; m_lock[i] = 1'b0; m_cnt[i] = 0;
                    end else begin
                        m_st[i] = legal_next(m_st[i], c);
                    end
                end else if (m_st[i] == M_VBID) begin
                    if (m_vbid[i][0] && !d[0]) e.sof = 1'b1;
                    m_vbid[i] = d; e.upd = 1'b1; m_st[i] = M_MVID;
                end else if (m_st[i] == M_MVID) begin
                    m_mvid[i] = d; m_st[i] = M_MAUD;
                end else if (m_st[i] == M_MAUD) begin
                    m_lock[i] = 1'b1; m_st[i] = M_BLANK;
                end else if (m_st[i] == M_ACTIVE) begin
                    e.vld[j] = 1'b1;
                    if (m_cnt[i] < 65535) m_cnt[i]++;
                end
            end
        end
        e.lock = m_lock[i]; e.vbid = m_vbid[i]; e.vs = m_vbid[i][0];
        e.mvid = m_mvid[i]; e.len = m_len[i];
        eq[i].push_back(e);
    endtask

    // Driver: a marker entry (bit 11) becomes a whole lane-disabled word; short words pad with data 0x00.
    always @(negedge clk) begin
        if (drv_on) begin
            for (int i = 0; i < 2; i++) begin
                int n;
                logic [43:0] w;
                logic en;
                logic [11:0] s;
                n = (i == 0) ? 2 : 4;
                w = '0;
                en = 1'b1;
                if (sq[i].size() > 0 && sq[i][0][11]) begin
                    s = sq[i].pop_front();
                    en = 1'b0;
                end else begin
                    for (int j = 0; j < n; j++) begin
                        if (sq[i].size() > 0 && !sq[i][0][11]) begin
                            s = sq[i].pop_front();
                            w[j*11+:11] = s[10:0];
                        end
                    end
                end
                if (i == 0) begin din2 = w[21:0]; en2 = en; end
                else        begin din4 = w;       en4 = en; end
                apply_word(i, w, en, n);
            end
        end
    end

    // Monitor: one registered output word per clock per instance.
    always @(posedge clk) begin
        exp_t e;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (eq[i].size() > 0) begin
                e = eq[i].pop_front();
                chk($sformatf("dat[%0d]", i),  (i == 0) ? {16'h0, dat2} : dat4, e.dat);
                chk($sformatf("vld[%0d]", i),  (i == 0) ? {2'b0, vld2} : vld4, {28'h0, e.vld});
                chk($sformatf("lock[%0d]", i), lock_o[i], e.lock);
                chk($sformatf("vbid[%0d]", i), vbid_o[i], e.vbid);
                chk($sformatf("vbid_upd[%0d]", i), upd_o[i], e.upd);
                chk($sformatf("mvid[%0d]", i), mvid_o[i], e.mvid);
                chk($sformatf("vs[%0d]", i),   vs_o[i], e.vs);
                chk($sformatf("sof[%0d]", i),  sof_o[i], e.sof);
                chk($sformatf("bs[%0d]", i),   bs_o[i], e.bs);
                chk($sformatf("be[%0d]", i),   be_o[i], e.be);
                chk($sformatf("len[%0d]", i),  len_o[i], e.len);
                chk($sformatf("len_upd[%0d]", i), lupd_o[i], e.lupd);
                chk($sformatf("err[%0d]", i),  err_o[i], e.err);
            end
        end
    end

    task automatic push(input logic [11:0] s);
        sq[0].push_back(s);
        sq[1].push_back(s);
    endtask
    task automatic pd(input logic [7:0] b);
        push({1'b0, 2'($urandom_range(0, 3)), 1'b0, b});
    endtask
    task automatic pk(input logic [7:0] code);
        push({3'b000, 1'b1, code});
    endtask
    task automatic pen_low();
        push(12'h800);
    endtask
    task automatic frame_hdr(input logic [7:0] vb, input logic [7:0] mv);
        pk(8'hBC); pd(vb); pd(mv); pd(8'h00);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sq[0].size() != 0 || sq[1].size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d/%0d symbols left, required 0", sq[0].size(), sq[1].size());
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic chk_both_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_lock"}, lock_o[i], 0);
            chk({tag, "_vbid"}, vbid_o[i], 0);
            chk({tag, "_len"},  len_o[i], 0);
            chk({tag, "_err"},  err_o[i], 0);
        end
        chk({tag, "_vld2"}, vld2, 0);
        chk({tag, "_vld4"}, vld4, 0);
    endtask

    task automatic rand_line();
        int n;
        logic [7:0] errk [7];
        errk = '{8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'hF7, 8'h3C, 8'h7C};
        if ($urandom_range(0, 1) == 0) pk(8'hBC); else pk(8'h1C);
        pd(8'($urandom_range(0, 1))); pd(8'($urandom)); pd(8'($urandom));
        if ($urandom_range(0, 3) == 0) begin
            pk(8'h5C);
            repeat ($urandom_range(0, 4)) pd(8'($urandom));
            pk(8'hFD);
        end
        repeat ($urandom_range(0, 3)) pd(8'($urandom));
        pk(8'hFB);
        n = $urandom_range(0, 40);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                pk(8'hFE);
                repeat ($urandom_range(0, 3)) pd(8'h00);
                pk(8'hF7);
            end
            if ($urandom_range(0, 60) == 0) pk(errk[$urandom_range(0, 6)]);
            if ($urandom_range(0, 120) == 0) pen_low();
            pd(8'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0; en2 = 1'b1; en4 = 1'b1; din2 = '0; din4 = '0;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        chk_both_zero("reset");
        #1;
        rst_n = 1'b1;
        drv_on = 1'b1;
        repeat (4) @(posedge clk);

        // Lock-up and header capture.
        frame_hdr(8'h01, 8'h12);
        drain();
        for (int i = 0; i < 2; i++) begin
            chk("s1_vbid", vbid_o[i], 8'h01);
            chk("s1_mvid", mvid_o[i], 8'h12);
            chk("s1_lock", lock_o[i], 1);
            chk("s1_vs",   vs_o[i], 1);
        end

        // 100-symbol active line, BE in slot 1 of the 2-slot lane; next header starts a frame.
        pd(8'h00); pk(8'hFB);
        for (int k = 0; k < 100; k++) pd(8'(k));
        frame_hdr(8'h00, 8'h34);
        drain();
        for (int i = 0; i < 2; i++) begin
            chk("s2_len", len_o[i], 100);
            chk("s2_vs",  vs_o[i], 0);
        end

        // Fill inside an active line.
        pk(8'hFB);
        for (int k = 0; k < 10; k++) pd(8'(k + 8'h40));
        pk(8'hFE); pd(8'h00); pd(8'h00); pd(8'h00); pk(8'hF7);
        for (int k = 0; k < 10; k++) pd(8'(k + 8'h50));
        frame_hdr(8'h01, 8'h55);
        drain();
        for (int i = 0; i < 2; i++) chk("s3_len", len_o[i], 20);

        // Frame start signalled through SR.
        pk(8'h1C); pd(8'h00); pd(8'h66); pd(8'h00);
        drain();
        for (int i = 0; i < 2; i++) chk("s4_vs", vs_o[i], 0);

        // Fatal FE in blank, relock, then unknown K mid-line.
        pk(8'hF7); pd(8'h11); pd(8'h22);
        frame_hdr(8'h01, 8'h02);
        pk(8'hFB);
        for (int k = 0; k < 5; k++) pd(8'(k));
        pk(8'h3C);
        for (int k = 0; k < 5; k++) pd(8'(k));
        frame_hdr(8'h00, 8'h03);
        drain();
        for (int i = 0; i < 2; i++) chk("s5_len", len_o[i], 10);

        // Lane disable mid-line, then an 8-symbol line.
        pk(8'hFB);
        for (int k = 0; k < 37; k++) pd(8'(k));
        pen_low();
        for (int k = 0; k < 8; k++) pd(8'(k));
        frame_hdr(8'h01, 8'h02);
        pk(8'hFB);
        for (int k = 0; k < 8; k++) pd(8'(k));
        frame_hdr(8'h00, 8'h04);
        drain();
        for (int i = 0; i < 2; i++) begin
            chk("s6_len",  len_o[i], 8);
            chk("s6_mvid", mvid_o[i], 8'h04);
        end

        for (int r = 0; r < 120; r++) rand_line();
        frame_hdr(8'h00, 8'h07);
        drain();

        // Asynchronous reset in the middle of a line.
        frame_hdr(8'h01, 8'h09);
        pk(8'hFB);
        for (int k = 0; k < 30; k++) pd(8'(k));
        repeat (10) @(posedge clk);
        #2;
        drv_on = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_both_zero("arst");
        for (int i = 0; i < 2; i++) begin
            sq[i].delete();
            eq[i].delete();
        end
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drv_on = 1'b1;
        frame_hdr(8'h01, 8'h0A);
        pk(8'hFB);
        for (int k = 0; k < 4; k++) pd(8'(k));
        frame_hdr(8'h00, 8'h0B);
        drain();
        for (int i = 0; i < 2; i++) chk("arst_relock_len", len_o[i], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
